// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU instruction IDs, MIPS opcode/funct encodings and
// instruction field positions. Used by both the decode stage and alu_top.
package cpu_pkg;

    // ALU instruction IDs
    localparam logic [31:0] ID_ADD   = 32'd1;
    localparam logic [31:0] ID_SUB   = 32'd2;
    localparam logic [31:0] ID_ADDU  = 32'd3;
    localparam logic [31:0] ID_SUBU  = 32'd4;
    localparam logic [31:0] ID_ADDI  = 32'd5;
    localparam logic [31:0] ID_ADDIU = 32'd6;
    localparam logic [31:0] ID_AND   = 32'd7;
    localparam logic [31:0] ID_OR    = 32'd8;
    localparam logic [31:0] ID_ANDI  = 32'd9;
    localparam logic [31:0] ID_ORI   = 32'd10;
    localparam logic [31:0] ID_SLL   = 32'd11;
    localparam logic [31:0] ID_SRL   = 32'd12;
    localparam logic [31:0] ID_SLT   = 32'd24;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Instruction field bit ranges
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    // Source of the second ALU operand
    typedef enum logic [1:0] {
        OPB_REG,
        OPB_SHAMT,
        OPB_SEXT,
        OPB_ZEXT
    } opb_sel_e;

endpackage

// File: rtl/id_regfile.sv
// General-purpose register file: two combinational read ports with
// write-through from the writeback port; r0 is hard-wired to zero.
module id_regfile
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra_addr,
    output logic [XLEN-1:0] ra_data,
    input  logic [4:0]      rb_addr,
    output logic [XLEN-1:0] rb_data,
    input  logic            wen,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // A same-cycle writeback is visible to the reader so issue need not wait a cycle.
    always_comb begin
        ra_data = regs[ra_addr];
        if (ra_addr == 5'd0) begin
            ra_data = '0;
        end else if (wen && (waddr == ra_addr)) begin
            ra_data = wdata;
        end
    end

    always_comb begin
        rb_data = regs[rb_addr];
        if (rb_addr == 5'd0) begin
            rb_data = '0;
        end else if (wen && (waddr == rb_addr)) begin
            rb_data = wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode/issue stage: decodes MIPS words to ALU instruction IDs, reads operands,
// tracks pending destinations in a scoreboard and hands a registered payload to execute.
module id_stage
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [31:0]     ex_instr_id,
    output logic [XLEN-1:0] ex_rs,
    output logic [XLEN-1:0] ex_rt,
    output logic [31:0]     ex_pc,
    output logic [4:0]      ex_rd_addr,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            illegal
);

    logic [5:0]  opcode_f;
    logic [5:0]  funct_f;
    logic [4:0]  rs_f;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  shamt_f;
    logic [15:0] imm_f;

    assign opcode_f = if_instr[OPCODE_HI:OPCODE_LO];
    assign funct_f  = if_instr[FUNCT_HI:FUNCT_LO];
    assign rs_f     = if_instr[RS_HI:RS_LO];
    assign rt_f     = if_instr[RT_HI:RT_LO];
    assign rd_f     = if_instr[RD_HI:RD_LO];
    assign shamt_f  = if_instr[SHAMT_HI:SHAMT_LO];
    assign imm_f    = if_instr[IMM_HI:IMM_LO];

    logic        dec_legal;
    logic [31:0] dec_id;
    logic [4:0]  dec_src_a;
    logic        dec_use_b;
    logic [4:0]  dec_dest;
    opb_sel_e    dec_opb;

    always_comb begin
        dec_legal = 1'b0;
        dec_id    = '0;
        dec_src_a = rs_f;
        dec_use_b = 1'b0;
        dec_dest  = 5'd0;
        dec_opb   = OPB_REG;
        case (opcode_f)
            OP_RTYPE: begin
                dec_dest = rd_f;
                case (funct_f)
                    FN_ADD:  begin dec_legal = 1'b1; dec_id = ID_ADD;  dec_use_b = 1'b1; end
                    FN_SUB:  begin dec_legal = 1'b1; dec_id = ID_SUB;  dec_use_b = 1'b1; end
                    FN_ADDU: begin dec_legal = 1'b1; dec_id = ID_ADDU; dec_use_b = 1'b1; end
                    FN_SUBU: begin dec_legal = 1'b1; dec_id = ID_SUBU; dec_use_b = 1'b1; end
                    FN_AND:  begin dec_legal = 1'b1; dec_id = ID_AND;  dec_use_b = 1'b1; end
                    FN_OR:   begin dec_legal = 1'b1; dec_id = ID_OR;   dec_use_b = 1'b1; end
                    FN_SLT:  begin dec_legal = 1'b1; dec_id = ID_SLT;  dec_use_b = 1'b1; end
                    // Shifts take their value from rt and the amount from shamt.
                    FN_SLL:  begin dec_legal = 1'b1; dec_id = ID_SLL; dec_src_a = rt_f; dec_opb = OPB_SHAMT; end
                    FN_SRL:  begin dec_legal = 1'b1; dec_id = ID_SRL; dec_src_a = rt_f; dec_opb = OPB_SHAMT; end
                    default: ;
                endcase
            end
            OP_ADDI:  begin dec_legal = 1'b1; dec_id = ID_ADDI;  dec_dest = rt_f; dec_opb = OPB_SEXT; end
            OP_ADDIU: begin dec_legal = 1'b1; dec_id = ID_ADDIU; dec_dest = rt_f; dec_opb = OPB_SEXT; end
            OP_ANDI:  begin dec_legal = 1'b1; dec_id = ID_ANDI;  dec_dest = rt_f; dec_opb = OPB_ZEXT; end
            OP_ORI:   begin dec_legal = 1'b1; dec_id = ID_ORI;   dec_dest = rt_f; dec_opb = OPB_ZEXT; end
            default: ;
        endcase
    end

    logic [XLEN-1:0] ra_data;
    logic [XLEN-1:0] rb_data;

    id_regfile #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (dec_src_a),
        .ra_data (ra_data),
        .rb_addr (rt_f),
        .rb_data (rb_data),
        .wen     (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    logic [XLEN-1:0] opb_value;

    always_comb begin
        opb_value = rb_data;
        unique case (dec_opb)
            OPB_REG:   opb_value = rb_data;
            OPB_SHAMT: opb_value = XLEN'(shamt_f);
            OPB_SEXT:  opb_value = {{(XLEN-16){imm_f[15]}}, imm_f};
            OPB_ZEXT:  opb_value = {{(XLEN-16){1'b0}}, imm_f};
        endcase
    end

    logic            ex_valid_reg;
    logic [31:0]     ex_instr_id_reg;
    logic [XLEN-1:0] ex_rs_reg;
    logic [XLEN-1:0] ex_rt_reg;
    logic [31:0]     ex_pc_reg;
    logic [4:0]      ex_rd_addr_reg;
    logic            illegal_reg;

    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] pend_eff;
    logic            hazard;
    logic            accept;
    logic            issue;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            assign clr_vec[gi] = wb_en && (wb_addr == 5'(gi));
            if (gi == 0) begin : g_r0
                assign set_vec[gi] = 1'b0;
            end else begin : g_rn
                assign set_vec[gi] = issue && (dec_dest == 5'(gi));
            end
        end
    endgenerate

    // A writeback landing this cycle already releases its register.
    assign pend_eff     = pending_reg & ~clr_vec;
    assign pending_next = pend_eff | set_vec;

    assign hazard   = dec_legal & (pend_eff[dec_src_a]
                                   | (dec_use_b & pend_eff[rt_f])
                                   | pend_eff[dec_dest]);
    assign if_ready = (~ex_valid_reg | ex_ready) & ~hazard;
    assign accept   = if_valid & if_ready;
    assign issue    = accept & dec_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg     <= '0;
            ex_valid_reg    <= 1'b0;
            ex_instr_id_reg <= '0;
            ex_rs_reg       <= '0;
            ex_rt_reg       <= '0;
            ex_pc_reg       <= '0;
            ex_rd_addr_reg  <= '0;
            illegal_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            illegal_reg <= accept & ~dec_legal;
            if (issue) begin
                ex_valid_reg    <= 1'b1;
                ex_instr_id_reg <= dec_id;
                ex_rs_reg       <= ra_data;
                ex_rt_reg       <= opb_value;
                ex_pc_reg       <= if_pc;
                ex_rd_addr_reg  <= dec_dest;
            end else if (ex_ready) begin
                ex_valid_reg <= 1'b0;
            end
        end
    end

    assign ex_valid    = ex_valid_reg;
    assign ex_instr_id = ex_instr_id_reg;
    assign ex_rs       = ex_rs_reg;
    assign ex_rt       = ex_rt_reg;
    assign ex_pc       = ex_pc_reg;
    assign ex_rd_addr  = ex_rd_addr_reg;
    assign illegal     = illegal_reg;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: decode, operand read, scoreboard stalls,
// backpressure, illegal words and reset behaviour.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr_id;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd_addr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    id_stage #(.NREG(32), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_instr_id (ex_instr_id),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_pc       (ex_pc),
        .ex_rd_addr  (ex_rd_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick();
        wb_en   = 1'b0;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    initial begin
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        ex_ready = 1'b1;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_ex_id", ex_instr_id, 32'd0);
        chk("rst_ex_rs", ex_rs, 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);

        // add r3, r1, r2
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd7);
        present(32'h00221820, 32'h100);
        chk("add_if_ready", 32'(if_ready), 32'd1);
        tick();
        chk("add_ex_valid", 32'(ex_valid), 32'd1);
        chk("add_id", ex_instr_id, 32'd1);
        chk("add_rs", ex_rs, 32'd5);
        chk("add_rt", ex_rt, 32'd7);
        chk("add_rd", 32'(ex_rd_addr), 32'd3);
        chk("add_pc", ex_pc, 32'h100);

        // addi r4, r3, -1 must wait for r3
        present(32'h2064FFFF, 32'h104);
        chk("raw_stall0", 32'(if_ready), 32'd0);
        tick();
        chk("raw_drain_valid", 32'(ex_valid), 32'd0);
        chk("raw_stall1", 32'(if_ready), 32'd0);
        wb_en   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'd12;
        #1;
        chk("raw_release", 32'(if_ready), 32'd1);
        tick();
        wb_en = 1'b0;
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_id", ex_instr_id, 32'd5);
        chk("addi_rs_bypass", ex_rs, 32'd12);
        chk("addi_rt_sext", ex_rt, 32'hFFFFFFFF);
        chk("addi_rd", 32'(ex_rd_addr), 32'd4);
        chk("addi_pc", ex_pc, 32'h104);

        // Backpressure with sll r5, r1, 4 waiting
        ex_ready = 1'b0;
        present(32'h00012900, 32'h108);
        chk("bp_if_ready", 32'(if_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", 32'(ex_valid), 32'd1);
            chk("bp_hold_id", ex_instr_id, 32'd5);
            chk("bp_hold_rs", ex_rs, 32'd12);
            chk("bp_if_ready_hold", 32'(if_ready), 32'd0);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_release", 32'(if_ready), 32'd1);
        tick();
        chk("sll_id", ex_instr_id, 32'd11);
        chk("sll_rs", ex_rs, 32'd5);
        chk("sll_rt_shamt", ex_rt, 32'd4);
        chk("sll_rd", 32'(ex_rd_addr), 32'd5);
        chk("sll_pc", ex_pc, 32'h108);

        // ori r6, r0, 0x8000 back-to-back
        present(32'h34068000, 32'h10C);
        chk("ori_if_ready", 32'(if_ready), 32'd1);
        tick();
        chk("ori_valid", 32'(ex_valid), 32'd1);
        chk("ori_id", ex_instr_id, 32'd10);
        chk("ori_rs", ex_rs, 32'd0);
        chk("ori_rt_zext", ex_rt, 32'h00008000);
        chk("ori_rd", 32'(ex_rd_addr), 32'd6);

        // Undecodable word
        present(32'hFC000000, 32'h110);
        chk("ill_if_ready", 32'(if_ready), 32'd1);
        tick();
        if_valid = 1'b0;
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_ex_valid", 32'(ex_valid), 32'd0);
        tick();
        chk("ill_pulse_end", 32'(illegal), 32'd0);

        // r0 writes are dropped, even via write-through
        wb_write(5'd0, 32'hDEAD);
        wb_en   = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'hDEAD;
        present(32'h00003820, 32'h114);
        chk("r0_no_stall", 32'(if_ready), 32'd1);
        tick();
        wb_en = 1'b0;
        chk("r0_id", ex_instr_id, 32'd1);
        chk("r0_rs", ex_rs, 32'd0);
        chk("r0_rt", ex_rt, 32'd0);
        chk("r0_rd", 32'(ex_rd_addr), 32'd7);

        // All-zero word is sll r0,r0,0
        present(32'h00000000, 32'h118);
        tick();
        chk("nop_valid", 32'(ex_valid), 32'd1);
        chk("nop_id", ex_instr_id, 32'd11);
        chk("nop_rd", 32'(ex_rd_addr), 32'd0);

        // WAW: ori r5 while r5 still pending from sll
        present(32'h34050001, 32'h11C);
        chk("waw_stall", 32'(if_ready), 32'd0);

        // Reset mid-issue with payload held and hazard present
        ex_ready = 1'b0;
        present(32'h2064FFFF, 32'h120);
        chk("pre_rst_if_ready", 32'(if_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("mid_rst_illegal", 32'(illegal), 32'd0);
        chk("mid_rst_if_ready", 32'(if_ready), 32'd1);
        chk("mid_rst_ex_id", ex_instr_id, 32'd0);
        if_valid = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        ex_ready = 1'b1;
        present(32'h00221820, 32'h200);
        tick();
        if_valid = 1'b0;
        chk("post_rst_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_rs", ex_rs, 32'd0);
        chk("post_rst_rt", ex_rt, 32'd0);
        chk("post_rst_pc", ex_pc, 32'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
